// File: rtl/ysyx_23060203_axi_rarb_pkg.sv
// Shared types and constants for the three-master AXI read arbiter.
// Holds the FSM encoding, grant indices, response codes and the packed channel bundles.
package ysyx_23060203_pkg;

    localparam int unsigned ID_W = 4;

    // Bit positions inside the one-hot grant vector {ifu, lsu, mmu}
    localparam int unsigned GNT_MMU = 0;
    localparam int unsigned GNT_LSU = 1;
    localparam int unsigned GNT_IFU = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_AR   = 3'b010,
        ST_R    = 3'b100
    } rarb_state_t;

    typedef struct packed {
        logic            arvalid;
        logic [31:0]     araddr;
        logic [ID_W-1:0] arid;
        logic [7:0]      arlen;
        logic [2:0]      arsize;
        logic [1:0]      arburst;
    } ar_chan_t;

    typedef struct packed {
        logic            rvalid;
        logic [31:0]     rdata;
        logic [1:0]      rresp;
        logic            rlast;
        logic [ID_W-1:0] rid;
    } r_chan_t;

    // Final beat of a burst accepted this cycle
    function automatic logic r_last_hs(r_chan_t r, logic rready);
        return r.rvalid & rready & r.rlast;
    endfunction

endpackage

// File: rtl/ysyx_23060203_axi_rarb_if.sv
// AXI read-channel bundle shared by the MMU, LSU, IFU and memory sides of the arbiter.
// 'in' is the subordinate view (arbiter facing a master), 'out' the manager view.
interface axi_if;
    import ysyx_23060203_pkg::*;

    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    modport in (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );

    modport out (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

endinterface

// File: rtl/ysyx_23060203_axi_rarb_pick.sv
// Combinational request picker: MMU always first, then LSU/IFU.
// YSYX_23060203_RARB_RR_EN makes LSU/IFU alternate via rr_ptr (0 favours LSU); else LSU > IFU.
module ysyx_23060203_rarb_pick
    import ysyx_23060203_pkg::*;
#(
    parameter int unsigned ARB_W = 3
) (
    input  logic [ARB_W-1:0] req,
    input  logic             rr_ptr,
    output logic [ARB_W-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[GNT_MMU]) begin
            gnt[GNT_MMU] = 1'b1;
`ifdef YSYX_23060203_RARB_RR_EN
        end else if (req[GNT_LSU] && req[GNT_IFU]) begin
            if (rr_ptr) begin
                gnt[GNT_IFU] = 1'b1;
            end else begin
                gnt[GNT_LSU] = 1'b1;
            end
`endif
        end else if (req[GNT_LSU]) begin
            gnt[GNT_LSU] = 1'b1;
        end else if (req[GNT_IFU]) begin
            gnt[GNT_IFU] = 1'b1;
        end
    end

`ifndef YSYX_23060203_RARB_RR_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;
`endif

endmodule

// File: rtl/ysyx_23060203_axi_rarb.sv
// Three-master AXI read arbiter (MMU PTW, LSU, IFU) onto one memory read channel.
// One transaction at a time; YSYX_23060203_RARB_RR_EN adds an LSU/IFU round-robin pointer.
module ysyx_23060203_axi_rarb
    import ysyx_23060203_pkg::*;
#(
    parameter int unsigned ARB_W = 3
) (
    input  logic clock,
    input  logic reset,
    axi_if.in    mmu_r,
    axi_if.in    lsu_r,
    axi_if.in    ifu_r,
    axi_if.out   mem_r
);

    rarb_state_t      state_q, state_d;
    logic [ARB_W-1:0] gnt_q, gnt_d;
    logic [ARB_W-1:0] req;
    logic [ARB_W-1:0] pick_gnt;
    logic             rr_ptr;

    ar_chan_t mmu_ar, lsu_ar, ifu_ar, ar_sel, ar_out;
    r_chan_t  mem_rsp, r_mmu, r_lsu, r_ifu;
    logic     rready_sel;
    logic     in_ar, in_r;
    logic     ar_hs, r_done;

    assign req = {ifu_r.arvalid, lsu_r.arvalid, mmu_r.arvalid};

    assign in_ar = (state_q == ST_AR);
    assign in_r  = (state_q == ST_R);

    ysyx_23060203_rarb_pick #(
        .ARB_W (ARB_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt)
    );

    // ---------------------------------------------------------------- AR path
    assign mmu_ar = {mmu_r.arvalid, mmu_r.araddr, mmu_r.arid, mmu_r.arlen, mmu_r.arsize,
                     mmu_r.arburst};
    assign lsu_ar = {lsu_r.arvalid, lsu_r.araddr, lsu_r.arid, lsu_r.arlen, lsu_r.arsize,
                     lsu_r.arburst};
    assign ifu_ar = {ifu_r.arvalid, ifu_r.araddr, ifu_r.arid, ifu_r.arlen, ifu_r.arsize,
                     ifu_r.arburst};

    // AND-OR mux; gnt_q is one-hot whenever it is consulted
    assign ar_sel = ({$bits(ar_chan_t){gnt_q[GNT_MMU]}} & mmu_ar)
                  | ({$bits(ar_chan_t){gnt_q[GNT_LSU]}} & lsu_ar)
                  | ({$bits(ar_chan_t){gnt_q[GNT_IFU]}} & ifu_ar);

    assign ar_out = in_ar ? ar_sel : '0;

    assign {mem_r.arvalid, mem_r.araddr, mem_r.arid, mem_r.arlen, mem_r.arsize,
            mem_r.arburst} = ar_out;

    assign mmu_r.arready = in_ar & gnt_q[GNT_MMU] & mem_r.arready;
    assign lsu_r.arready = in_ar & gnt_q[GNT_LSU] & mem_r.arready;
    assign ifu_r.arready = in_ar & gnt_q[GNT_IFU] & mem_r.arready;

    assign ar_hs = ar_out.arvalid & mem_r.arready;

    // ----------------------------------------------------------------- R path
    assign mem_rsp = {mem_r.rvalid, mem_r.rdata, mem_r.rresp, mem_r.rlast, mem_r.rid};

    assign rready_sel = |(gnt_q & {ifu_r.rready, lsu_r.rready, mmu_r.rready});
    assign mem_r.rready = in_r & rready_sel;

    assign r_mmu = (in_r && gnt_q[GNT_MMU]) ? mem_rsp : '0;
    assign r_lsu = (in_r && gnt_q[GNT_LSU]) ? mem_rsp : '0;
    assign r_ifu = (in_r && gnt_q[GNT_IFU]) ? mem_rsp : '0;

    assign {mmu_r.rvalid, mmu_r.rdata, mmu_r.rresp, mmu_r.rlast, mmu_r.rid} = r_mmu;
    assign {lsu_r.rvalid, lsu_r.rdata, lsu_r.rresp, lsu_r.rlast, lsu_r.rid} = r_lsu;
    assign {ifu_r.rvalid, ifu_r.rdata, ifu_r.rresp, ifu_r.rlast, ifu_r.rid} = r_ifu;

    // Error responses do not end the burst early; only rlast does
    assign r_done = in_r & r_last_hs(mem_rsp, rready_sel);

    // -------------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_gnt;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                // A master withdrawing arvalid keeps its grant; no re-arbitration
                if (ar_hs) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (r_done) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef YSYX_23060203_RARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    // Flip only when the favoured master just finished a transaction it won
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (r_done && ((gnt_q[GNT_LSU] && !rr_ptr_q) || (gnt_q[GNT_IFU] && rr_ptr_q))) begin
            rr_ptr_d = ~rr_ptr_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060203_axi_rarb.sv
// Scoreboard bench for ysyx_23060203_axi_rarb: directed requests push expected AR/R events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_ysyx_23060203_axi_rarb;
    import ysyx_23060203_pkg::*;

    logic clock;
    logic reset;

    axi_if mmu_r ();
    axi_if lsu_r ();
    axi_if ifu_r ();
    axi_if mem_r ();

    ysyx_23060203_axi_rarb #(
        .ARB_W (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mmu_r (mmu_r),
        .lsu_r (lsu_r),
        .ifu_r (ifu_r),
        .mem_r (mem_r)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Master-side drive, index 0 = MMU, 1 = LSU, 2 = IFU
    logic [2:0]  m_arvalid;
    logic [31:0] m_araddr [3];
    logic [7:0]  m_arlen  [3];
    logic [2:0]  m_rready;

    assign mmu_r.arvalid = m_arvalid[0];
    assign mmu_r.araddr  = m_araddr[0];
    assign mmu_r.arlen   = m_arlen[0];
    assign mmu_r.arid    = 4'd0;
    assign mmu_r.arsize  = 3'd2;
    assign mmu_r.arburst = 2'b01;
    assign mmu_r.rready  = m_rready[0];
    assign lsu_r.arvalid = m_arvalid[1];
    assign lsu_r.araddr  = m_araddr[1];
    assign lsu_r.arlen   = m_arlen[1];
    assign lsu_r.arid    = 4'd1;
    assign lsu_r.arsize  = 3'd2;
    assign lsu_r.arburst = 2'b01;
    assign lsu_r.rready  = m_rready[1];
    assign ifu_r.arvalid = m_arvalid[2];
    assign ifu_r.araddr  = m_araddr[2];
    assign ifu_r.arlen   = m_arlen[2];
    assign ifu_r.arid    = 4'd2;
    assign ifu_r.arsize  = 3'd2;
    assign ifu_r.arburst = 2'b01;
    assign ifu_r.rready  = m_rready[2];

    typedef struct packed {
        logic        is_r;
        logic [2:0]  src;
        logic [31:0] val;
        logic [7:0]  aux;
        logic        last;
    } ev_t;

    ev_t sb[$];
    int  n_vec  = 0;
    int  n_miss = 0;
    logic gap_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_ar(input logic [2:0] src, input logic [31:0] addr, input logic [7:0] len);
        sb.push_back('{is_r: 1'b0, src: src, val: addr, aux: len, last: 1'b0});
    endtask

    task automatic exp_r(input logic [2:0] src, input logic [31:0] data, input logic [1:0] resp,
                         input logic last);
        sb.push_back('{is_r: 1'b1, src: src, val: data, aux: {6'd0, resp}, last: last});
    endtask

    function automatic logic [2:0] ar_rdy_vec();
        return {ifu_r.arready, lsu_r.arready, mmu_r.arready};
    endfunction

    function automatic logic [2:0] rvalid_vec();
        return {ifu_r.rvalid, lsu_r.rvalid, mmu_r.rvalid};
    endfunction

    // Memory contents: address echo, except one PTE word and one faulting beat
    function automatic logic [31:0] mem_word(input logic [31:0] addr, input int b);
        return (addr == 32'h8000_1004) ? 32'h2000_0C01 : addr + 32'(b * 4);
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] addr, input int b);
        return (addr == 32'h4000_0100 && b == 0) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    // ------------------------------------------------------------ memory model
    initial begin : mem_model
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [ID_W-1:0] id;
        logic            hs;
        logic            abort;
        mem_r.arready = 1'b1;
        mem_r.rvalid  = 1'b0;
        mem_r.rdata   = '0;
        mem_r.rresp   = '0;
        mem_r.rlast   = 1'b0;
        mem_r.rid     = '0;
        forever begin
            @(negedge clock);
            if (!reset && mem_r.arvalid) begin
                addr  = mem_r.araddr;
                len   = mem_r.arlen;
                id    = mem_r.arid;
                abort = 1'b0;
                @(posedge clock);
                #1;
                for (int b = 0; b <= int'(len) && !abort; b++) begin
                    mem_r.rvalid = 1'b1;
                    mem_r.rdata  = mem_word(addr, b);
                    mem_r.rresp  = mem_resp(addr, b);
                    mem_r.rlast  = (b == int'(len));
                    mem_r.rid    = id;
                    hs = 1'b0;
                    while (!hs && !abort) begin
                        @(negedge clock);
                        hs    = mem_r.rready;
                        abort = reset;
                        @(posedge clock);
                        #1;
                    end
                end
                mem_r.rvalid = 1'b0;
                mem_r.rdata  = '0;
                mem_r.rresp  = '0;
                mem_r.rlast  = 1'b0;
                mem_r.rid    = '0;
            end
        end
    end

    // ----------------------------------------------------------------- monitor
    task automatic monitor_step();
        ev_t         e;
        logic [2:0]  rv;
        logic [31:0] d, others;
        logic [1:0]  rs;
        logic        lst;
        if (gap_pend) begin
            chk("idle_gap", {30'd0, mem_r.arvalid, mem_r.rready}, 32'd0);
            gap_pend = 1'b0;
        end
        if (mem_r.arvalid && mem_r.arready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_ar: got AR addr 0x%08h, required no transfer",
                         mem_r.araddr);
            end else begin
                e = sb.pop_front();
                if (e.is_r) begin
                    n_miss++;
                    $display("FAIL ar_order: got AR addr 0x%08h, required R beat 0x%08h",
                             mem_r.araddr, e.val);
                end else begin
                    chk("ar_src", 32'(ar_rdy_vec()), 32'(e.src));
                    chk("ar_addr", mem_r.araddr, e.val);
                    chk("ar_len", 32'(mem_r.arlen), 32'(e.aux));
                end
            end
        end
        rv = rvalid_vec();
        if (|(rv & m_rready)) begin
            d      = (rv[0] ? mmu_r.rdata : 32'd0) | (rv[1] ? lsu_r.rdata : 32'd0)
                   | (rv[2] ? ifu_r.rdata : 32'd0);
            others = (!rv[0] ? mmu_r.rdata : 32'd0) | (!rv[1] ? lsu_r.rdata : 32'd0)
                   | (!rv[2] ? ifu_r.rdata : 32'd0);
            rs     = (rv[0] ? mmu_r.rresp : 2'd0) | (rv[1] ? lsu_r.rresp : 2'd0)
                   | (rv[2] ? ifu_r.rresp : 2'd0);
            lst    = (rv[0] & mmu_r.rlast) | (rv[1] & lsu_r.rlast) | (rv[2] & ifu_r.rlast);
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_r: got beat 0x%08h, required no transfer", d);
            end else begin
                e = sb.pop_front();
                if (!e.is_r) begin
                    n_miss++;
                    $display("FAIL r_order: got R beat 0x%08h, required AR addr 0x%08h",
                             d, e.val);
                end else begin
                    chk("r_src", 32'(rv), 32'(e.src));
                    chk("r_data", d, e.val);
                    chk("r_resp", 32'(rs), 32'(e.aux));
                    chk("r_last", 32'(lst), 32'(e.last));
                    chk("r_other_data_zero", others, 32'd0);
                    if (e.last) gap_pend = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) monitor_step();
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic req(input logic [1:0] m, input logic [31:0] addr, input logic [7:0] len);
        logic [2:0] rdy;
        int         cyc;
        m_araddr[m]  = addr;
        m_arlen[m]   = len;
        m_arvalid[m] = 1'b1;
        cyc = 0;
        rdy = '0;
        while (!rdy[m] && cyc < 300) begin
            @(negedge clock);
            rdy = ar_rdy_vec();
            cyc++;
        end
        if (!rdy[m]) begin
            n_vec++;
            n_miss++;
            $display("FAIL ar_timeout: got no arready for master %0d, required grant", m);
        end
        @(posedge clock);
        #1;
        m_arvalid[m] = 1'b0;
        m_araddr[m]  = '0;
        m_arlen[m]   = '0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || gap_pend) && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 500) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d events pending, required 0", sb.size());
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        m_arvalid = '0;
        m_rready  = 3'b111;
        for (int i = 0; i < 3; i++) begin
            m_araddr[i] = '0;
            m_arlen[i]  = '0;
        end

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_arvalid", 32'(mem_r.arvalid), 32'd0);
        chk("rst_mem_rready", 32'(mem_r.rready), 32'd0);
        chk("rst_arready", 32'(ar_rdy_vec()), 32'd0);
        chk("rst_rvalid", 32'(rvalid_vec()), 32'd0);
        chk("rst_mem_araddr", mem_r.araddr, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single MMU read with one-cycle arbitration latency
        exp_ar(3'b001, 32'h8000_1004, 8'd0);
        exp_r(3'b001, 32'h2000_0C01, RESP_OKAY, 1'b1);
        fork
            req(2'd0, 32'h8000_1004, 8'd0);
            begin
                @(negedge clock);
                chk("lat_cycle_n", 32'(mem_r.arvalid), 32'd0);
                @(negedge clock);
                chk("lat_cycle_n1", 32'(mem_r.arvalid), 32'd1);
            end
        join
        wait_idle();

        // Simultaneous requests: MMU, LSU, IFU
        exp_ar(3'b001, 32'h8000_2000, 8'd0);
        exp_r(3'b001, 32'h8000_2000, RESP_OKAY, 1'b1);
        exp_ar(3'b010, 32'h1000_0010, 8'd0);
        exp_r(3'b010, 32'h1000_0010, RESP_OKAY, 1'b1);
        exp_ar(3'b100, 32'h3000_0040, 8'd0);
        exp_r(3'b100, 32'h3000_0040, RESP_OKAY, 1'b1);
        fork
            req(2'd0, 32'h8000_2000, 8'd0);
            req(2'd1, 32'h1000_0010, 8'd0);
            req(2'd2, 32'h3000_0040, 8'd0);
        join
        wait_idle();

        // IFU 4-beat burst with toggling rready, LSU raised mid-burst
        exp_ar(3'b100, 32'h3000_0000, 8'd3);
        for (int i = 0; i < 4; i++) begin
            exp_r(3'b100, 32'h3000_0000 + 32'(i * 4), RESP_OKAY, i == 3);
        end
        exp_ar(3'b010, 32'h1000_0080, 8'd0);
        exp_r(3'b010, 32'h1000_0080, RESP_OKAY, 1'b1);
        fork
            begin
                req(2'd2, 32'h3000_0000, 8'd3);
                repeat (2) @(posedge clock);
                #1;
                req(2'd1, 32'h1000_0080, 8'd0);
            end
            begin
                repeat (16) begin
                    @(posedge clock);
                    #1;
                    m_rready[2] = ~m_rready[2];
                end
                m_rready[2] = 1'b1;
            end
        join
        wait_idle();

        // LSU 2-beat burst with SLVERR on beat 0
        exp_ar(3'b010, 32'h4000_0100, 8'd1);
        exp_r(3'b010, 32'h4000_0100, RESP_SLVERR, 1'b0);
        exp_r(3'b010, 32'h4000_0104, RESP_OKAY, 1'b1);
        req(2'd1, 32'h4000_0100, 8'd1);
        wait_idle();

        // Fresh pointer state for the LSU/IFU contention run
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

`ifdef YSYX_23060203_RARB_RR_EN
        exp_ar(3'b010, 32'h1000_0100, 8'd0);
        exp_r(3'b010, 32'h1000_0100, RESP_OKAY, 1'b1);
        exp_ar(3'b100, 32'h3000_0100, 8'd0);
        exp_r(3'b100, 32'h3000_0100, RESP_OKAY, 1'b1);
        exp_ar(3'b010, 32'h1000_0104, 8'd0);
        exp_r(3'b010, 32'h1000_0104, RESP_OKAY, 1'b1);
        exp_ar(3'b100, 32'h3000_0104, 8'd0);
        exp_r(3'b100, 32'h3000_0104, RESP_OKAY, 1'b1);
        fork
            begin
                req(2'd1, 32'h1000_0100, 8'd0);
                req(2'd1, 32'h1000_0104, 8'd0);
            end
            begin
                req(2'd2, 32'h3000_0100, 8'd0);
                req(2'd2, 32'h3000_0104, 8'd0);
            end
        join
`else
        for (int i = 0; i < 4; i++) begin
            exp_ar(3'b010, 32'h1000_0100 + 32'(i * 4), 8'd0);
            exp_r(3'b010, 32'h1000_0100 + 32'(i * 4), RESP_OKAY, 1'b1);
        end
        exp_ar(3'b100, 32'h3000_0100, 8'd0);
        exp_r(3'b100, 32'h3000_0100, RESP_OKAY, 1'b1);
        fork
            begin
                req(2'd1, 32'h1000_0100, 8'd0);
                req(2'd1, 32'h1000_0104, 8'd0);
                req(2'd1, 32'h1000_0108, 8'd0);
                req(2'd1, 32'h1000_010C, 8'd0);
            end
            req(2'd2, 32'h3000_0100, 8'd0);
        join
`endif
        wait_idle();

        // Reset pulsed while the IFU burst is stalled in the R phase
        m_rready[2] = 1'b0;
        exp_ar(3'b100, 32'h3000_0200, 8'd1);
        req(2'd2, 32'h3000_0200, 8'd1);
        @(posedge clock);
        #2;
        chk("stall_ifu_rvalid", 32'(ifu_r.rvalid), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_ifu_rvalid", 32'(ifu_r.rvalid), 32'd0);
        chk("midrst_ifu_rdata", ifu_r.rdata, 32'd0);
        chk("midrst_mem_rready", 32'(mem_r.rready), 32'd0);
        chk("midrst_mem_arvalid", 32'(mem_r.arvalid), 32'd0);
        chk("midrst_arready", 32'(ar_rdy_vec()), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset       = 1'b0;
        m_rready[2] = 1'b1;
        @(posedge clock);
        #1;
        exp_ar(3'b100, 32'h3000_0300, 8'd0);
        exp_r(3'b100, 32'h3000_0300, RESP_OKAY, 1'b1);
        req(2'd2, 32'h3000_0300, 8'd0);
        wait_idle();

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_axi_rarb.md
# ysyx_23060203_axi_rarb

Three-master AXI read arbiter that merges the MMU page-table-walk read port, the LSU read port and the IFU read port onto the single memory-side AXI read channel. It sits directly downstream of the MMU's `mem_r` port and upstream of the memory/crossbar read port. Exactly one master owns the channel from address grant until its last read beat completes, so all transactions are strictly serialised.

## Interface
Parameters:
- `ARB_W`, 3: width of the one-hot grant vector, one bit per master; fixed at 3.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mmu_r`  axi_if.in  interface  MMU PTW read master; highest priority.
- `lsu_r`  axi_if.in  interface  LSU read master.
- `ifu_r`  axi_if.in  interface  IFU read master.
- `mem_r`  axi_if.out  interface  arbitrated read channel to memory.
- Signals carried on every AXI port: `arvalid`, `arready`, `araddr[31:0]`, `arid`, `arlen[7:0]`, `arsize[2:0]`, `arburst[1:0]`, `rvalid`, `rready`, `rdata[31:0]`, `rresp[1:0]`, `rlast`, `rid`.

## Operation
- State machine, one-hot: `ST_IDLE`, `ST_AR`, `ST_R`. Registered grant `gnt[2:0]`, one-hot {ifu, lsu, mmu}; it is all-zero in `ST_IDLE`.
- `ST_IDLE`: if any master asserts `arvalid`, pick a winner, load `gnt`, and go to `ST_AR`. With no request, stay in `ST_IDLE`.
- Pick rule: MMU first, then LSU, then IFU. The MMU always wins because both other masters stall on it.
- `ST_AR`: `mem_r.ar*` is driven from the granted master, and `mem_r.arready` is routed back only to that master. On `arvalid & arready`, go to `ST_R`.
- `ST_R`: `mem_r.r*` is routed to the granted master, and `mem_r.rready` is taken from that master. On `rvalid & rready & rlast`, go to `ST_IDLE` and clear `gnt`.
- Non-granted masters see `arready=0` and `rvalid=0`, with `rdata`, `rresp`, `rlast` and `rid` at 0.
- In `ST_IDLE`: `mem_r.arvalid=0`, `mem_r.rready=0`, and `mem_r.ar*` payload is 0.
- `rresp` is passed through unmodified. An error response does not abort the burst; completion still waits for `rlast`.
- If the granted master drops `arvalid` before the handshake (an AXI violation), the arbiter holds `ST_AR` and the grant; it does not re-arbitrate.
- Requests arriving while busy are not queued. Each master must keep `arvalid` asserted until it is granted.

## Timing
- Reset values: state `ST_IDLE`, `gnt=0`, RR pointer favours LSU. All outputs are 0 (`arvalid`, `rready`, all `arready`/`rvalid`, payloads).
- Arbitration latency: request seen in IDLE at cycle n, so `mem_r.arvalid` is high at cycle n+1.
- AR and R paths are combinational pass-through of the granted master, with no added latency per beat.
- Minimum gap: one `ST_IDLE` cycle after every `rlast` beat before the next `mem_r.arvalid`.
- Simultaneous requests in IDLE are resolved by the pick rule in that same cycle.
- Reset asserted mid-burst: immediate return to `ST_IDLE` and the grant is dropped. Beats still in flight downstream are not tracked, so the memory side must be reset together with the arbiter.

## Configuration
- `YSYX_23060203_RARB_RR_EN` defined: LSU and IFU share second priority round-robin. A 1-bit pointer flips to the other master after each completed transaction that the pointer-favoured master won. MMU stays highest priority.
- Not defined: fixed priority MMU > LSU > IFU, and no pointer register exists.

## Structure
- Shared package `ysyx_23060203_pkg`: the `rarb_state_t` one-hot enum, the grant index constants `GNT_MMU=0`, `GNT_LSU=1`, `GNT_IFU=2`, and AXI response constants `RESP_OKAY`/`RESP_SLVERR`.
- Sub-module `ysyx_23060203_rarb_pick`: combinational request-to-one-hot picker. It takes the request vector and the RR pointer, and contains the macro-dependent logic. The top level holds the FSM and the muxes.

## Test plan
- Single MMU read, `araddr=0x8000_1004`, `arlen=0` → `mem_r.arvalid` one cycle after the request; that `rdata=0x2000_0C01` is delivered only to `mmu_r`; back in IDLE the cycle after the beat.
- MMU, LSU and IFU all request in the same IDLE cycle → served in order MMU, LSU, IFU, each separated by one IDLE cycle.
- IFU burst `arlen=3` with `rready` toggling every cycle → all 4 beats delivered in order; LSU request raised mid-burst is not granted until after `rlast`.
- With `RR_EN`: LSU and IFU both request continuously for 4 transactions → LSU, IFU, LSU, IFU. Without `RR_EN` → LSU ×4.
- `rresp=SLVERR` on beat 0 of a 2-beat LSU burst → both beats forwarded with their `rresp`; FSM completes on `rlast`.
- `reset` pulsed while in `ST_R` → all outputs 0 in the same cycle, state `ST_IDLE`; a fresh IFU request is granted normally after release.
